// File: rtl/universal_shift_register.sv
// Universal shift register: hold/load/clear plus 1-bit-per-cycle shift/rotate bursts
// under a valid/ready command handshake, with abort.
//
// state    | meaning
// ST_IDLE  | ready for a command; single-cycle ops and the first shift step happen here
// ST_SHIFT | burst running, one step per edge until remaining count reaches zero
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shift_amt,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             abort,
  output logic [WIDTH-1:0] parallel_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic [2:0]       mode_q;
  logic             done_q;
  logic [CNT_W-1:0] n_sat;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] step_1(input logic [WIDTH-1:0] r, input logic [2:0] op,
                                              input logic sl, input logic sr);
    logic [WIDTH-1:0] res;
    res = r;
    case (op)
      M_SHL:   res = {r[WIDTH-2:0], sr};
      M_SHR:   res = {sl, r[WIDTH-1:1]};
      M_ROL:   res = {r[WIDTH-2:0], r[WIDTH-1]};
      M_ROR:   res = {r[0], r[WIDTH-1:1]};
      M_ASR:   res = {r[WIDTH-1], r[WIDTH-1:1]};
      default: res = r;
    endcase
    return res;
  endfunction

  assign n_sat    = (shift_amt > W_CNT) ? W_CNT : shift_amt;
  assign is_shift = (mode != M_HOLD) && (mode != M_LOAD) && (mode != M_CLR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid && is_shift && (n_sat > ONE)) state_d = ST_SHIFT;
      ST_SHIFT: if (abort || (rem_q == ONE)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_SHIFT: busy      = 1'b1;
      default:  cmd_ready = 1'b0;
    endcase
  end

  // The accept edge already performs the first step, so the burst only covers N-1 further steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= M_HOLD;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_SHIFT) begin
        if (abort) begin
          rem_q <= '0;
        end else begin
          data_q <= step_1(data_q, mode_q, ser_in_l, ser_in_r);
          rem_q  <= rem_q - ONE;
          done_q <= (rem_q == ONE);
        end
      end else if (cmd_valid) begin
        case (mode)
          M_HOLD: done_q <= 1'b1;
          M_LOAD: begin
            data_q <= parallel_in;
            done_q <= 1'b1;
          end
          M_CLR: begin
            data_q <= '0;
            done_q <= 1'b1;
          end
          default: begin
            mode_q <= mode;
            if (n_sat != '0) data_q <= step_1(data_q, mode, ser_in_l, ser_in_r);
            if (n_sat <= ONE) done_q <= 1'b1;
            else              rem_q  <= n_sat - ONE;
          end
        endcase
      end
    end
  end

  assign parallel_out = data_q;
  assign ser_out_l    = data_q[WIDTH-1];
  assign ser_out_r    = data_q[0];
  assign done         = done_q;

endmodule
